// File: rtl/sha256_msg_loader.sv
// sha256_msg_loader
//
// Byte-serial message loader in front of the sha256 core. Bytes come in over
// a valid/ready handshake and are packed MSB-first into a zero-filled 1024-bit
// buffer. The finished message is held stable, together with its bit length
// and an overflow flag, until the consumer acknowledges it.
//
// Ports
//   clk           single clock, all logic on posedge
//   rst           synchronous active-high reset
//   in_byte       message byte, bit 7 is the first message bit of the byte
//   in_valid      in_byte / in_last valid this cycle
//   in_last       current byte is the final byte of the message
//   in_ready      loader accepts a byte (LOAD state)
//   binary_input  assembled message, bit 0 is the first message bit
//   input_length  message length in bits (stored bytes * 8)
//   msg_valid     message outputs complete and stable (HOLD state)
//   msg_ack       consumer has taken the message, used only in HOLD
//   msg_err       at least one byte of the current message was dropped
//
// state | meaning
// LOAD  | accepting bytes, in_ready=1
// HOLD  | message frozen and presented, msg_valid=1, waiting for msg_ack

module sha256_msg_loader #(
  parameter int MAX_BYTES = 119
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [7:0]    in_byte,
  input  logic          in_valid,
  input  logic          in_last,
  output logic          in_ready,
  output logic [0:1023] binary_input,
  output logic [0:9]    input_length,
  output logic          msg_valid,
  input  logic          msg_ack,
  output logic          msg_err
);

  typedef enum logic {
    LOAD = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [6:0] MAX_CNT = 7'(MAX_BYTES);

  state_t        state_q, state_d;
  logic [6:0]    cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [0:1023] buf_q, buf_d;
  logic [9:0]    wr_base;

  // Bit position of the next byte; fits in 10 bits because cnt <= 127.
  assign wr_base = {cnt_q, 3'b000};

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= LOAD;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      buf_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      buf_q   <= buf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    buf_d   = buf_q;
    unique case (state_q)
      LOAD: begin
        if (in_valid) begin
          if (cnt_q < MAX_CNT) begin
            buf_d[wr_base +: 8] = in_byte;
            cnt_d               = cnt_q + 7'd1;
          end else begin
            // Buffer full: byte is dropped, error stays set until ack/reset.
            err_d = 1'b1;
          end
          if (in_last) begin
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (msg_ack) begin
          buf_d   = '0;
          cnt_d   = '0;
          err_d   = 1'b0;
          state_d = LOAD;
        end
      end
      default: state_d = LOAD;
    endcase
  end

  assign in_ready     = (state_q == LOAD);
  assign msg_valid    = (state_q == HOLD);
  assign binary_input = buf_q;
  assign input_length = {cnt_q, 3'b000};
  assign msg_err      = err_q;

endmodule

// File: tb/tb_sha256_msg_loader.sv
module tb_sha256_msg_loader;

  logic          clk;
  logic          rst;
  logic [7:0]    in_byte;
  logic          in_valid;
  logic          in_last;
  logic          in_ready;
  logic [0:1023] binary_input;
  logic [0:9]    input_length;
  logic          msg_valid;
  logic          msg_ack;
  logic          msg_err;

  int total;
  int bad;

  sha256_msg_loader #(.MAX_BYTES(119)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_byte      (in_byte),
    .in_valid     (in_valid),
    .in_last      (in_last),
    .in_ready     (in_ready),
    .binary_input (binary_input),
    .input_length (input_length),
    .msg_valid    (msg_valid),
    .msg_ack      (msg_ack),
    .msg_err      (msg_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change on negedge; one byte is offered for exactly one posedge.
  task automatic send(input logic [7:0] b, input logic last);
    in_byte  = b;
    in_valid = 1'b1;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_byte  = 8'h00;
  endtask

  task automatic pulse_ack();
    msg_ack = 1'b1;
    @(negedge clk);
    msg_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b want=1", in_ready); end
    total++; if (msg_valid !== 1'b0) begin bad++; $display("FAIL reset_msg_valid got=%b want=0", msg_valid); end
    total++; if (msg_err !== 1'b0) begin bad++; $display("FAIL reset_msg_err got=%b want=0", msg_err); end
    total++; if (input_length !== 10'd0) begin bad++; $display("FAIL reset_length got=%0d want=0", input_length); end
    total++; if (binary_input !== '0) begin bad++; $display("FAIL reset_buf got[0:63]=%h want all zero", binary_input[0:63]); end
  endtask

  task automatic test_abc90();
    logic [0:1023] exp;
    logic [7:0] b;
    exp = '0;
    for (int i = 0; i < 90; i++) begin
      b = 8'(8'h61 + (i % 3));
      exp[8*i +: 8] = b;
      if (i == 89) begin
        total++; if (msg_valid !== 1'b0) begin bad++; $display("FAIL abc90_early_valid got=%b want=0", msg_valid); end
      end
      send(b, (i == 89));
    end
    total++; if (msg_valid !== 1'b1) begin bad++; $display("FAIL abc90_valid got=%b want=1", msg_valid); end
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL abc90_ready got=%b want=0", in_ready); end
    total++; if (input_length !== 10'd720) begin bad++; $display("FAIL abc90_length got=%0d want=720", input_length); end
    total++; if (msg_err !== 1'b0) begin bad++; $display("FAIL abc90_err got=%b want=0", msg_err); end
    total++; if (binary_input !== exp) begin bad++; $display("FAIL abc90_buf %0d bits differ got[0:63]=%h want[0:63]=%h", $countones(binary_input ^ exp), binary_input[0:63], exp[0:63]); end
    pulse_ack();
    total++; if (msg_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL abc90_ack_hs got valid=%b ready=%b want 0/1", msg_valid, in_ready); end
    total++; if (binary_input !== '0 || input_length !== 10'd0) begin bad++; $display("FAIL abc90_ack_clear got len=%0d ones=%0d want 0/0", input_length, $countones(binary_input)); end
  endtask

  task automatic test_single();
    logic [0:1023] exp;
    exp = '0;
    exp[0:7] = 8'b01100001;
    send(8'h61, 1'b1);
    total++; if (msg_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%b want=1", msg_valid); end
    total++; if (input_length !== 10'd8) begin bad++; $display("FAIL single_length got=%0d want=8", input_length); end
    total++; if (binary_input !== exp) begin bad++; $display("FAIL single_buf got[0:63]=%h want[0:63]=%h ones=%0d", binary_input[0:63], exp[0:63], $countones(binary_input)); end
    pulse_ack();
  endtask

  // Overflow message, then exercise HOLD while input keeps arriving.
  task automatic test_overflow_hold();
    logic [0:1023] exp;
    logic [7:0] b;
    exp = '0;
    for (int i = 0; i < 120; i++) begin
      b = 8'(i + 1);
      if (i < 119) exp[8*i +: 8] = b;
      send(b, (i == 119));
      if (i == 118) begin
        total++; if (msg_err !== 1'b0 || input_length !== 10'd952) begin bad++; $display("FAIL ovf_full got err=%b len=%0d want 0/952", msg_err, input_length); end
      end
    end
    total++; if (msg_valid !== 1'b1) begin bad++; $display("FAIL ovf_valid got=%b want=1", msg_valid); end
    total++; if (input_length !== 10'd952) begin bad++; $display("FAIL ovf_length got=%0d want=952", input_length); end
    total++; if (msg_err !== 1'b1) begin bad++; $display("FAIL ovf_err got=%b want=1", msg_err); end
    total++; if (binary_input[952:1023] !== '0) begin bad++; $display("FAIL ovf_tail got=%h want=0", binary_input[952:1023]); end
    total++; if (binary_input !== exp) begin bad++; $display("FAIL ovf_buf %0d bits differ got[896:959]=%h want[896:959]=%h", $countones(binary_input ^ exp), binary_input[896:959], exp[896:959]); end
    in_valid = 1'b1;
    in_byte  = 8'hAA;
    in_last  = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      total++; if (in_ready !== 1'b0 || msg_valid !== 1'b1) begin bad++; $display("FAIL hold_hs cyc=%0d got ready=%b valid=%b want 0/1", c, in_ready, msg_valid); end
      total++; if (binary_input !== exp || input_length !== 10'd952 || msg_err !== 1'b1) begin bad++; $display("FAIL hold_frozen cyc=%0d got len=%0d err=%b diff=%0d want 952/1/0", c, input_length, msg_err, $countones(binary_input ^ exp)); end
    end
    msg_ack = 1'b1;
    @(negedge clk);
    msg_ack  = 1'b0;
    in_valid = 1'b0;
    in_last  = 1'b0;
    total++; if (msg_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL hold_ack_hs got valid=%b ready=%b want 0/1", msg_valid, in_ready); end
    total++; if (binary_input !== '0 || msg_err !== 1'b0 || input_length !== 10'd0) begin bad++; $display("FAIL hold_ack_clear got ones=%0d err=%b len=%0d want 0/0/0", $countones(binary_input), msg_err, input_length); end
  endtask

  task automatic test_back_to_back();
    logic [0:1023] exp;
    exp = '0;
    exp[0:31] = 32'hFFFF_FFFF;
    msg_ack = 1'b1;
    for (int i = 0; i < 4; i++) send(8'hFF, (i == 3));
    total++; if (msg_valid !== 1'b1 || input_length !== 10'd32) begin bad++; $display("FAIL b2b_first got valid=%b len=%0d want 1/32", msg_valid, input_length); end
    total++; if (binary_input !== exp) begin bad++; $display("FAIL b2b_first_buf got[0:63]=%h want[0:63]=%h", binary_input[0:63], exp[0:63]); end
    @(negedge clk);
    total++; if (msg_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL b2b_one_hold got valid=%b ready=%b want 0/1", msg_valid, in_ready); end
    send(8'h00, 1'b1);
    total++; if (msg_valid !== 1'b1 || input_length !== 10'd8) begin bad++; $display("FAIL b2b_second got valid=%b len=%0d want 1/8", msg_valid, input_length); end
    total++; if (binary_input !== '0) begin bad++; $display("FAIL b2b_residue got[0:63]=%h want=0", binary_input[0:63]); end
    @(negedge clk);
    msg_ack = 1'b0;
  endtask

  task automatic test_reset_mid();
    logic [0:1023] exp;
    for (int i = 0; i < 10; i++) send(8'(8'hC0 + i), 1'b0);
    total++; if (input_length !== 10'd80) begin bad++; $display("FAIL rstmid_partial got=%0d want=80", input_length); end
    // Reset wins over a simultaneous byte.
    rst      = 1'b1;
    in_valid = 1'b1;
    in_byte  = 8'h5A;
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    in_byte  = 8'h00;
    total++; if (in_ready !== 1'b1 || msg_valid !== 1'b0 || msg_err !== 1'b0) begin bad++; $display("FAIL rstmid_hs got ready=%b valid=%b err=%b want 1/0/0", in_ready, msg_valid, msg_err); end
    total++; if (input_length !== 10'd0 || binary_input !== '0) begin bad++; $display("FAIL rstmid_clear got len=%0d ones=%0d want 0/0", input_length, $countones(binary_input)); end
    exp = '0;
    exp[0:23] = 24'h112233;
    msg_ack = 1'b1;  // ignored while loading
    send(8'h11, 1'b0);
    send(8'h22, 1'b0);
    msg_ack = 1'b0;
    send(8'h33, 1'b1);
    total++; if (msg_valid !== 1'b1 || input_length !== 10'd24) begin bad++; $display("FAIL rstmid_msg got valid=%b len=%0d want 1/24", msg_valid, input_length); end
    total++; if (binary_input !== exp) begin bad++; $display("FAIL rstmid_buf got[0:63]=%h want[0:63]=%h", binary_input[0:63], exp[0:63]); end
    // Reset while holding drops the message.
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (msg_valid !== 1'b0 || input_length !== 10'd0 || binary_input !== '0) begin bad++; $display("FAIL rsthold got valid=%b len=%0d ones=%0d want 0/0/0", msg_valid, input_length, $countones(binary_input)); end
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    rst      = 1'b1;
    in_byte  = 8'h00;
    in_valid = 1'b0;
    in_last  = 1'b0;
    msg_ack  = 1'b0;
    @(negedge clk);
    test_reset();
    test_abc90();
    test_single();
    test_overflow_hold();
    test_back_to_back();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
